// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_wb_arbiter                                              |
// | Purpose  : Shares the single register-file write port between the ALU     |
// |            writeback (port 0) and the load/memory writeback (port 1).      |
// |            Each port owns a 1-entry holding register behind a valid/ready  |
// |            handshake. Same-address writes drain oldest first, x0 writes    |
// |            are discarded at the handshake, and read-after-write hazards    |
// |            are flagged for entries still waiting in a hold.                |
// | Option   : WB_ROUND_ROBIN_EN - when defined, different-address contention |
// |            alternates between ports; otherwise port 0 always wins.        |
// | Ports    : clk, arst_n (async, active-low)                                 |
// |            req0_valid/addr/data -> req0_ready   ALU writeback             |
// |            req1_valid/addr/data -> req1_ready   MEM writeback             |
// |            raddr_1, raddr_2     -> hazard       decode-stage hazard check |
// |            rf_reg_write, rf_waddr, rf_wdata     registered RF write port  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module regfile_wb_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] raddr_1,
   input  logic [ADDR_W-1:0] raddr_2,
   output logic              hazard,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;

   // Holding registers
   logic              r_h0_valid;
   logic [ADDR_W-1:0] r_h0_addr;
   logic [DATA_W-1:0] r_h0_data;
   logic              r_h1_valid;
   logic [ADDR_W-1:0] r_h1_addr;
   logic [DATA_W-1:0] r_h1_data;

   // 1 = hold1 was loaded before hold0 (only meaningful when both are valid)
   logic              r_age;

   logic              w_both;
   logic              w_same_addr;
   logic              w_pick1;      // winner of different-address contention
   logic              w_grant0;
   logic              w_grant1;
   logic              w_load0;
   logic              w_load1;
   logic              w_stay1;
   logic              w_h0_next;
   logic              w_h1_next;
   logic              w_hz0;
   logic              w_hz1;

   assign w_both      = r_h0_valid & r_h1_valid;
   assign w_same_addr = (r_h0_addr == r_h1_addr);

`ifdef WB_ROUND_ROBIN_EN
   logic r_rr;

   assign w_pick1 = r_rr;

   // Pointer only moves when a different-address conflict was resolved by it
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_rr <= 1'b0;
      end else if (w_both && !w_same_addr) begin
         r_rr <= ~r_rr;
      end
   end
`else
   assign w_pick1 = 1'b0;
`endif

   // At most one grant per cycle
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (w_both) begin
         if (w_same_addr) begin
            w_grant1 = r_age;
            w_grant0 = ~r_age;
         end else begin
            w_grant1 = w_pick1;
            w_grant0 = ~w_pick1;
         end
      end else begin
         w_grant0 = r_h0_valid;
         w_grant1 = r_h1_valid;
      end
   end

   // A hold that drains this cycle can take a new entry on the same edge
   assign req0_ready = ~r_h0_valid | w_grant0;
   assign req1_ready = ~r_h1_valid | w_grant1;

   // Writes to x0 complete the handshake but never occupy a hold
   assign w_load0 = req0_valid & req0_ready & (req0_addr != c_ZERO_ADDR);
   assign w_load1 = req1_valid & req1_ready & (req1_addr != c_ZERO_ADDR);

   assign w_h0_next = w_load0 | (r_h0_valid & ~w_grant0);
   assign w_h1_next = w_load1 | (r_h1_valid & ~w_grant1);
   assign w_stay1   = r_h1_valid & ~w_grant1;

   // hold1 is older if it is alone, or if it stayed while hold0 was (re)loaded.
   // Simultaneous loads make hold0 the older one.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_age <= 1'b0;
      end else begin
         r_age <= w_h1_next & (~w_h0_next | w_stay1);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_h0_valid <= 1'b0;
         r_h0_addr  <= '0;
         r_h0_data  <= '0;
         r_h1_valid <= 1'b0;
         r_h1_addr  <= '0;
         r_h1_data  <= '0;
      end else begin
         r_h0_valid <= w_h0_next;
         r_h1_valid <= w_h1_next;
         if (w_load0) begin
            r_h0_addr <= req0_addr;
            r_h0_data <= req0_data;
         end
         if (w_load1) begin
            r_h1_addr <= req1_addr;
            r_h1_data <= req1_data;
         end
      end
   end

   // Registered register-file write port; address/data hold when idle
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rf_reg_write <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
      end else begin
         rf_reg_write <= w_grant0 | w_grant1;
         if (w_grant0) begin
            rf_waddr <= r_h0_addr;
            rf_wdata <= r_h0_data;
         end else if (w_grant1) begin
            rf_waddr <= r_h1_addr;
            rf_wdata <= r_h1_data;
         end
      end
   end

   // Only held entries count; the output stage is bypassed inside the RF
   assign w_hz0 = r_h0_valid & (r_h0_addr != c_ZERO_ADDR) &
                  ((r_h0_addr == raddr_1) | (r_h0_addr == raddr_2));
   assign w_hz1 = r_h1_valid & (r_h1_addr != c_ZERO_ADDR) &
                  ((r_h1_addr == raddr_1) | (r_h1_addr == raddr_2));
   assign hazard = w_hz0 | w_hz1;

endmodule
`default_nettype wire
